// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

endpackage

// File: rtl/fetch_unit_pc_unit.sv
// Program counter: register, +4 incrementer and branch redirect mux.
module pc_unit
  import fetch_unit_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_inc,
  input  logic              load_br,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_inc
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Wraps naturally modulo 2^ADDR_W.
  assign pc_inc = pc_q + ADDR_W'(PC_INC);
  assign pc     = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_br) begin
      pc_d = branch_addr & ALIGN_MASK;
    end else if (load_inc) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC & ALIGN_MASK;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM with one-entry instruction buffer.
// Optional FETCH_FLUSH_CNT_EN adds a saturating flush_count output.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_next
`ifdef FETCH_FLUSH_CNT_EN
  ,
  output logic [15:0]        flush_count
`endif
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_next_q, pc_next_d;
  logic               load_inc;
  logic               load_br;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_inc;

  pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .load_inc    (load_inc),
    .load_br     (load_br),
    .branch_addr (branch_addr),
    .pc          (pc),
    .pc_inc      (pc_inc)
  );

  assign imem_addr = pc;

  // The ack-cycle word bypasses the buffer so valid appears with zero latency.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    load_inc  = 1'b0;
    load_br   = 1'b0;
    imem_req  = 1'b0;
    valid     = 1'b0;
    instr     = instr_q;
    pc_next   = pc_next_q;
    if (rst) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (branch_taken) begin
            load_br = 1'b1;
            if (!imem_ack) begin
              state_d = ST_DISCARD;
            end
          end else if (imem_ack) begin
            instr_d   = imem_rdata;
            pc_next_d = pc_inc;
            load_inc  = 1'b1;
            valid     = 1'b1;
            instr     = imem_rdata;
            pc_next   = pc_inc;
            if (freeze) begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (branch_taken) begin
            load_br = 1'b1;
            state_d = ST_FETCH;
          end else begin
            valid = 1'b1;
            if (!freeze) begin
              state_d = ST_FETCH;
            end
          end
        end
        ST_DISCARD: begin
          // A redirect here retargets the PC; the in-flight ack is still owed.
          load_br = branch_taken;
          if (imem_ack) begin
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      instr_q   <= '0;
      pc_next_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
    end
  end

`ifdef FETCH_FLUSH_CNT_EN
  logic        drop;
  logic [15:0] flush_count_q, flush_count_d;

  assign drop = rst && (
                  (branch_taken && state_q == ST_FETCH && imem_ack) ||
                  (branch_taken && state_q == ST_HOLD) ||
                  (state_q == ST_DISCARD && imem_ack));

  always_comb begin
    flush_count_d = flush_count_q;
    if (drop && flush_count_q != 16'hFFFF) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_count_q <= '0;
    end else begin
      flush_count_q <= flush_count_d;
    end
  end

  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit; one vector per clock cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc_next;
`ifdef FETCH_FLUSH_CNT_EN
  logic [15:0] flush_count;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .valid        (valid),
    .instr        (instr),
    .pc_next      (pc_next)
`ifdef FETCH_FLUSH_CNT_EN
    ,
    .flush_count  (flush_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic        chk_addr;
    logic [31:0] addr;
    logic        valid;
    logic        chk_data;
    logic [31:0] instr;
    logic [31:0] pcn;
    logic        chk_flush;
    logic [15:0] flush;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(
    input logic rst_i, input logic frz, input logic br, input logic [31:0] baddr,
    input logic ack, input logic [31:0] rdata,
    input logic req, input logic ca, input logic [31:0] addr,
    input logic vld, input logic cd, input logic [31:0] ins, input logic [31:0] pcn,
    input logic cf, input logic [15:0] fl);
    vec_t v;
    v.rst = rst_i; v.frz = frz; v.br = br; v.baddr = baddr; v.ack = ack; v.rdata = rdata;
    v.req = req; v.chk_addr = ca; v.addr = addr; v.valid = vld; v.chk_data = cd;
    v.instr = ins; v.pcn = pcn; v.chk_flush = cf; v.flush = fl;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic ok;
    @(posedge clk);
    #1;
    rst          = v.rst;
    freeze       = v.frz;
    branch_taken = v.br;
    branch_addr  = v.baddr;
    imem_ack     = v.ack;
    imem_rdata   = v.rdata;
    @(negedge clk);
    ok = (imem_req === v.req) && (valid === v.valid);
    if (v.chk_addr)  ok = ok && (imem_addr === v.addr);
    if (v.chk_data)  ok = ok && (instr === v.instr) && (pc_next === v.pcn);
`ifdef FETCH_FLUSH_CNT_EN
    if (v.chk_flush) ok = ok && (flush_count === v.flush);
`endif
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h pc_next=%h, want req=%b addr=%h valid=%b instr=%h pc_next=%h",
               name, imem_req, imem_addr, valid, instr, pc_next,
               v.req, v.addr, v.valid, v.instr, v.pcn);
`ifdef FETCH_FLUSH_CNT_EN
      $display("FAIL %s flush: got %0d want %0d (checked=%b)", name, flush_count, v.flush, v.chk_flush);
`endif
    end
  endtask

  vec_t tbl[24];

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0;

    //            rst frz br baddr          ack rdata          req ca addr           vld cd instr          pc_next        cf fl
    tbl[0]  = mk(0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
    tbl[1]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0,         0, 1, 32'h0,         32'h0,         1, 0);
    tbl[2]  = mk(1, 0, 0, 32'h0,         1, 32'hA000_0000, 1, 1, 32'h0,         1, 1, 32'hA000_0000, 32'h4,         0, 0);
    tbl[3]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h4,         0, 0, 32'h0,         32'h0,         0, 0);
    tbl[4]  = mk(1, 0, 0, 32'h0,         1, 32'hA000_0001, 1, 1, 32'h4,         1, 1, 32'hA000_0001, 32'h8,         0, 0);
    tbl[5]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h8,         0, 0, 32'h0,         32'h0,         0, 0);
    tbl[6]  = mk(1, 1, 0, 32'h0,         1, 32'hA000_0002, 1, 1, 32'h8,         1, 1, 32'hA000_0002, 32'hC,         0, 0);
    tbl[7]  = mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 1, 32'hA000_0002, 32'hC,         0, 0);
    tbl[8]  = mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 1, 32'hA000_0002, 32'hC,         0, 0);
    tbl[9]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 1, 32'hA000_0002, 32'hC,         0, 0);
    tbl[10] = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'hC,         0, 0, 32'h0,         32'h0,         0, 0);
    tbl[11] = mk(1, 0, 1, 32'h100,       0, 32'h0,         1, 1, 32'hC,         0, 0, 32'h0,         32'h0,         0, 0);
    tbl[12] = mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         1, 0);
    tbl[13] = mk(1, 0, 0, 32'h0,         1, 32'hB000_0000, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
    tbl[14] = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h100,       0, 0, 32'h0,         32'h0,         1, 1);
    tbl[15] = mk(1, 0, 1, 32'h203,       1, 32'hB000_0001, 1, 1, 32'h100,       0, 0, 32'h0,         32'h0,         0, 0);
    tbl[16] = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h200,       0, 0, 32'h0,         32'h0,         1, 2);
    tbl[17] = mk(1, 1, 0, 32'h0,         1, 32'hC000_0000, 1, 1, 32'h200,       1, 1, 32'hC000_0000, 32'h204,       0, 0);
    tbl[18] = mk(1, 1, 1, 32'hFFFF_FFFE, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
    tbl[19] = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0,         1, 3);
    tbl[20] = mk(1, 0, 0, 32'h0,         1, 32'hD000_0000, 1, 1, 32'hFFFF_FFFC, 1, 1, 32'hD000_0000, 32'h0,         0, 0);
    tbl[21] = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
    tbl[22] = mk(0, 0, 0, 32'h0,         1, 32'hE000_0000, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
    tbl[23] = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0,         0, 1, 32'h0,         32'h0,         1, 0);

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i], $sformatf("tbl[%0d]", i));
    end

    // Back-to-back stream from PC 0: address then ack with pc_next = addr+4.
    for (int k = 0; k < 4; k++) begin
      apply(mk(1, 0, 0, 32'h0, 0, 32'h0, 1, 1, 32'(4 * k), 0, 0, 32'h0, 32'h0, 0, 0),
            $sformatf("stream_req[%0d]", k));
      apply(mk(1, 0, 0, 32'h0, 1, 32'hF000_0000 + 32'(k), 1, 1, 32'(4 * k),
               1, 1, 32'hF000_0000 + 32'(k), 32'(4 * k + 4), 0, 0),
            $sformatf("stream_ack[%0d]", k));
    end

    // Second redirect while a flushed ack is still outstanding.
    apply(mk(1, 0, 1, 32'h40, 0, 32'h0, 1, 1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 0), "disc_br1");
    apply(mk(1, 0, 1, 32'h80, 0, 32'h0, 0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 0, 0), "disc_br2");
    apply(mk(1, 0, 0, 32'h0,  1, 32'h1234_5678, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0), "disc_drop");
    apply(mk(1, 0, 0, 32'h0,  0, 32'h0, 1, 1, 32'h80, 0, 0, 32'h0, 32'h0, 1, 1), "disc_refetch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
